// File: rtl/synth_timing_pkg.sv
// Shared timing definitions for the synth measurement blocks.
package synth_timing_pkg;

    localparam int unsigned CLK_FREQ_HZ = 100_000_000;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meter_state_t;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector: rise is a one-cycle pulse the cycle after
// the input is first seen high, so a held level gives exactly one rise.
module rise_detect (
    input  logic clk_100mhz,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic in_q;

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            in_q <= 1'b0;
            rise <= 1'b0;
        end else begin
            in_q <= in;
            rise <= in & ~in_q;
        end
    end

endmodule

// File: rtl/pulse_period_meter.sv
// Measures the rise-to-rise interval of pulse_in in clk_100mhz cycles and
// hands each measurement to a consumer over a valid/ready port.
module pulse_period_meter
    import synth_timing_pkg::*;
#(
    parameter  int unsigned MAX_PERIOD   = 100_000_000,
    localparam int          PERIOD_WIDTH = $clog2(64'(MAX_PERIOD) + 64'd1)
) (
    input  logic                    clk_100mhz,
    input  logic                    rst,
    input  logic                    pulse_in,
    output logic [PERIOD_WIDTH-1:0] period_out,
    output logic                    period_valid,
    input  logic                    period_ready,
    output logic                    timeout,
    output logic                    overrun,
    output logic                    active
);

    localparam logic [PERIOD_WIDTH-1:0] MAX_CNT = PERIOD_WIDTH'(MAX_PERIOD);
    localparam logic [PERIOD_WIDTH-1:0] ONE     = PERIOD_WIDTH'(1);

    meter_state_t            state;
    logic [PERIOD_WIDTH-1:0] counter;
    logic                    rise;

    rise_detect u_rise_detect (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .in         (pulse_in),
        .rise       (rise)
    );

    // Handshake: period_valid/period_out hold steady until a cycle with
    // period_valid & period_ready, which consumes the value; valid drops the
    // next cycle unless a capture lands in that same cycle. A capture while
    // the held value is unconsumed overwrites it and sets sticky overrun.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state        <= IDLE;
            counter      <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            overrun      <= 1'b0;
            active       <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (period_valid && period_ready) begin
                period_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    counter <= '0;
                    if (rise) begin
                        state   <= MEASURE;
                        counter <= ONE;
                        active  <= 1'b1;
                    end
                end
                MEASURE: begin
                    // A rise on the MAX_CNT cycle still captures; timeout only without one.
                    if (rise) begin
                        period_out   <= counter;
                        period_valid <= 1'b1;
                        counter      <= ONE;
                        if (period_valid && !period_ready) begin
                            overrun <= 1'b1;
                        end
                    end else if (counter == MAX_CNT) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                        counter <= '0;
                        active  <= 1'b0;
                    end else begin
                        counter <= counter + ONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    counter <= '0;
                    active  <= 1'b0;
                end
            endcase
        end
    end

endmodule
